// File: rtl/uart_cmd_rx.sv
// 8N1 UART command receiver: decodes command bytes into single-cycle event
// pulses and exposes the last good byte plus a framing-error pulse.
module uart_cmd_rx #(
  parameter int          CLK_FREQ   = 65_000_000,
  parameter int          BAUD       = 115_200,
  parameter logic [7:0]  CLICK_CODE = 8'h43,
  parameter logic [7:0]  RST_CODE   = 8'h52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       click_pulse,
  output logic       rst_req,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          click_q, click_d;
  logic          rreq_q, rreq_d;

  // Two-stage synchroniser for the asynchronous line, idling high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      click_q <= 1'b0;
      rreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      click_q <= click_d;
      rreq_q  <= rreq_d;
    end
  end

  // Frame sequencing: mid-bit sampling, stop-bit check and command decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    click_d = 1'b0;
    rreq_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is high again at its midpoint is a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            click_d = (shift_q == CLICK_CODE);
            rreq_d  = (shift_q == RST_CODE);
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        // Hold off until the line returns high so a break cannot retrigger.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign click_pulse = click_q;
  assign rst_req     = rreq_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with an event scoreboard.
module tb_uart_cmd_rx;

  localparam int CPB  = 65_000_000 / 115_200;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, click_pulse, rst_req, busy;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       click;
    logic       rreq;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_valid_cyc = -1;
  int   k;

  uart_cmd_rx #(
    .CLK_FREQ  (65_000_000),
    .BAUD      (115_200),
    .CLICK_CODE(8'h43),
    .RST_CODE  (8'h52)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .click_pulse(click_pulse),
    .rst_req    (rst_req),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_cyc(CPB);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic expect_evt(input logic [7:0] d, input logic v, input logic f,
                            input logic c, input logic r);
    exp_t x;
    x.data = d; x.valid = v; x.ferr = f; x.click = c; x.rreq = r;
    q.push_back(x);
  endtask

  // Scoreboard: every output pulse cycle must match the next expected event.
  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err || click_pulse || rst_req)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {28'd0, rx_valid, frame_err, click_pulse, rst_req}, 32'd0);
      end else begin
        e = q.pop_front();
        check("rx_valid",    {31'd0, rx_valid},    {31'd0, e.valid});
        check("frame_err",   {31'd0, frame_err},   {31'd0, e.ferr});
        check("click_pulse", {31'd0, click_pulse}, {31'd0, e.click});
        check("rst_req",     {31'd0, rst_req},     {31'd0, e.rreq});
        check("rx_data",     {24'd0, rx_data},     {24'd0, e.data});
        if (rx_valid) last_valid_cyc = cyc;
      end
    end
  end

  initial begin
    rst   = 1'b1;
    rx_in = 1'b1;
    wait_cyc(3);
    check("rst_rx_data",   {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid",  {31'd0, rx_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_click",     {31'd0, click_pulse}, 32'd0);
    check("rst_rst_req",   {31'd0, rst_req}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_cyc(5);

    // Click command, busy during and after the frame.
    expect_evt(8'h43, 1'b1, 1'b0, 1'b1, 1'b0);
    fork
      send_byte(8'h43, 1'b1);
      begin
        wait_cyc(4 * CPB);
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
      end
    join
    wait_cyc(CPB);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    check("q_empty_click", q.size(), 32'd0);

    // Back-to-back reset-request then plain byte.
    expect_evt(8'h52, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_evt(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h52, 1'b1);
    send_byte(8'h55, 1'b1);
    wait_cyc(CPB);
    check("q_empty_b2b", q.size(), 32'd0);

    // Short low glitch on an idle line.
    rx_in = 1'b0;
    wait_cyc(10);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    wait_cyc(90);
    rx_in = 1'b1;
    wait_cyc(HALF + 3 - 100);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    wait_cyc(CPB);

    // Framing error followed by a held break, then a clean frame.
    expect_evt(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h43, 1'b0);
    wait_cyc(3 * CPB);
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_rx_data", {24'd0, rx_data}, 32'h55);
    rx_in = 1'b1;
    wait_cyc(2 * CPB);
    check("q_empty_ferr", q.size(), 32'd0);
    expect_evt(8'h43, 1'b1, 1'b0, 1'b1, 1'b0);
    send_byte(8'h43, 1'b1);
    wait_cyc(CPB);
    check("q_empty_after_ferr", q.size(), 32'd0);

    // Reset during data bit 4 discards the partial frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h43 >> i));
    rx_in = 1'b0;
    wait_cyc(CPB / 2);
    rst   = 1'b1;
    rx_in = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(2 * CPB);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rx_data", {24'd0, rx_data}, 32'd0);
    expect_evt(8'h43, 1'b1, 1'b0, 1'b1, 1'b0);
    send_byte(8'h43, 1'b1);
    wait_cyc(CPB);
    check("q_empty_abort", q.size(), 32'd0);

    // Latency from falling edge to rx_valid for 0xFF.
    expect_evt(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    k = cyc;
    send_byte(8'hFF, 1'b1);
    wait_cyc(CPB);
    check("q_empty_latency", q.size(), 32'd0);
    check("latency_window",
          {31'd0, ((last_valid_cyc - k) >= LAT - 2) && ((last_valid_cyc - k) <= LAT + 2)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
